// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative M-extension unit: funct3 opcodes, FSM states and
// signedness-class helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // Signedness class: bit 1 = rs1 signed, bit 0 = rs2 signed.
    localparam logic [1:0] CLS_UU = 2'b00;
    localparam logic [1:0] CLS_SU = 2'b10;
    localparam logic [1:0] CLS_SS = 2'b11;

    function automatic logic [1:0] sign_class(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: sign_class = CLS_SS;
            OP_MULHSU:               sign_class = CLS_SU;
            default:                 sign_class = CLS_UU;
        endcase
    endfunction

    // MUL reuses any stored product (its low half ignores signedness); MULH* needs the
    // product of its own class. DIV<->REM and DIVU<->REMU share one quotient/remainder pair.
    function automatic logic fuse_sibling(input logic [2:0] prev_op, input logic [1:0] prev_cls,
                                          input logic [2:0] op);
        if (!op[2] && !prev_op[2]) begin
            fuse_sibling = ((op == OP_MUL) != (prev_op == OP_MUL)) &&
                           ((op == OP_MUL) || (sign_class(op) == prev_cls));
        end else begin
            fuse_sibling = op[2] && prev_op[2] && (op[0] == prev_op[0]) && (op[1] != prev_op[1]);
        end
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a W-bit value.
module muldiv_negate #(
    parameter int unsigned W = 8
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FUSE_EN to reuse the previous product / quotient-remainder for sibling ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, sa, sb, div_zero, div_ovf, fast_path, fuse_hit;
    logic [XLEN-1:0]   mag_a, mag_b, quot_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;

    assign accept    = start && (state_q == S_IDLE);
    assign sa        = sign_class(funct3)[1] & a[XLEN-1];
    assign sb        = sign_class(funct3)[0] & b[XLEN-1];
    assign div_zero  = funct3[2] && (b == '0);
    assign div_ovf   = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign fast_path = div_zero || div_ovf;

    muldiv_negate #(.W(XLEN)) u_neg_a (.en(sa), .din(a), .dout(mag_a));
    muldiv_negate #(.W(XLEN)) u_neg_b (.en(sb), .din(b), .dout(mag_b));
    muldiv_negate #(.W(2*XLEN)) u_neg_prod (
        .en(sign_a_q ^ sign_b_q), .din(acc_q), .dout(prod_fix)
    );
    muldiv_negate #(.W(XLEN)) u_neg_quot (
        .en(sign_a_q ^ sign_b_q), .din(acc_q[XLEN-1:0]), .dout(quot_fix)
    );
    muldiv_negate #(.W(XLEN)) u_neg_rem (
        .en(sign_a_q), .din(acc_q[2*XLEN-1:XLEN]), .dout(rem_fix)
    );

    // acc holds {upper, multiplier} while multiplying and {remainder, quotient} while dividing.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_trial - {1'b0, opnd_q};

`ifdef MULDIV_FUSE_EN
    logic            tag_valid_q;
    logic [XLEN-1:0] tag_a_q, tag_b_q;
    logic [1:0]      tag_cls_q;
    logic [2:0]      tag_op_q;

    assign fuse_hit = tag_valid_q && (a == tag_a_q) && (b == tag_b_q) &&
                      fuse_sibling(tag_op_q, tag_cls_q, funct3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= 1'b0;
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            tag_cls_q   <= CLS_UU;
            tag_op_q    <= OP_MUL;
        end else if (accept) begin
            if (fast_path) begin
                tag_valid_q <= 1'b0;
            end else if (fuse_hit) begin
                tag_op_q <= funct3;
            end else begin
                tag_valid_q <= 1'b1;
                tag_a_q     <= a;
                tag_b_q     <= b;
                tag_cls_q   <= sign_class(funct3);
                tag_op_q    <= funct3;
            end
        end
    end
`else
    assign fuse_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = funct3;
                    cnt_d = CNT_W'(XLEN);
                    if (fast_path) begin
                        // Final values are loaded directly, so the sign fix must be a no-op.
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                        acc_d    = div_zero ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a};
                        state_d  = S_FIX;
                    end else if (fuse_hit) begin
                        state_d = S_FIX;
                    end else begin
                        sign_a_d = sa;
                        sign_b_d = sb;
                        if (funct3[2]) begin
                            opnd_d  = mag_b;
                            acc_d   = {{XLEN{1'b0}}, mag_a};
                            state_d = S_DIV;
                        end else begin
                            opnd_d  = mag_a;
                            acc_d   = {{XLEN{1'b0}}, mag_b};
                            state_d = S_MUL;
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_diff[XLEN]) begin
                    acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            default: begin
                if (!op_q[2]) begin
                    result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end else begin
                    result_d = op_q[1] ? rem_fix : quot_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RISC-V M-extension execute unit, parametrised in XLEN.
- Decodes funct3 into MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Computes with a shift-add multiplier and a restoring divider, one bit per cycle.
- Sits beside the main ALU. The multicycle controller dispatches to it when funct7 = 0000001 and waits on done.

Parameters:
- XLEN, 32, operand/result width (≥ 8, power of 2).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- funct3  in  3  operation select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
- a  in  XLEN  operand rs1
- b  in  XLEN  operand rs2
- busy  out  1  iteration in progress
- done  out  1  single-cycle pulse; result valid
- result  out  XLEN  registered result; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - Counter and all datapath registers are cleared.
  - Any operation in flight is discarded; no done is issued for it.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 (cycle 0):
  - Latch funct3.
  - Latch operand signs:
    - a is signed for MULH/MULHSU/DIV/REM.
    - b is signed for MULH/DIV/REM.
  - Latch magnitudes |a|, |b|.
  - Load counter = XLEN.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Fast paths, decided at start, go directly to FIX with no iterations:
  - Divide by zero (b=0):
    - DIV/DIVU quotient = all ones.
    - REM/REMU remainder = a unchanged.
  - Signed overflow (DIV/REM, a = 1<<(XLEN-1), b = all ones):
    - Quotient = a.
    - Remainder = 0.
- MUL state:
  - 2·XLEN-bit product register.
  - Each cycle: if multiplier LSB=1, add multiplicand into the upper half; shift right by 1; decrement counter.
  - At counter=1 → FIX.
- DIV state:
  - Restoring divide.
  - Each cycle: shift {rem, quot} left by 1; trial-subtract the divisor; keep the difference if it is ≥0 and set the quotient LSB.
  - At counter=1 → FIX.
- FIX state (one cycle):
  - Apply the sign fix:
    - Product is negated if sign_a^sign_b.
    - Quotient is negated if sign_a^sign_b.
    - Remainder is negated if sign_a.
  - Select the output: MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - Register result. Pulse done=1 in the following cycle, with state back in IDLE.
- Latency, start in cycle 0:
  - Normal operations: busy=1 in cycles 1..XLEN+1; done=1 in cycle XLEN+2 (cycle 34 at XLEN=32).
  - Fast paths: busy=1 in cycle 1 only; done=1 in cycle 2.
- start during the done cycle is accepted (back-to-back).
- start while busy=1 is ignored, with no side effects.
- Operands and funct3 are don't-care after the start cycle.

Optional Feature:
- MULDIV_FUSE_EN defined:
  - Unit retains the last full 2·XLEN product, or the last quotient+remainder pair, plus a tag {a, b, signedness class}.
  - On start, if the tag matches and the op is the sibling form (MULH*↔MUL with the same signedness class; DIV↔REM; DIVU↔REMU), skip iteration.
  - Fused request: done in cycle 2, busy=1 in cycle 1 only.
  - Tag is invalidated on reset and on any non-matching start.
- MULDIV_FUSE_EN undefined:
  - No tag storage.
  - Every request takes the full or fast-path latency above.

Decomposition:
- muldiv_pkg holds:
  - funct3 encodings as localparams (OP_MUL..OP_REMU).
  - State encoding (IDLE/MUL/DIV/FIX, 2 bits).
  - Helper predicate encodings for the signedness class.
- One sub-module: muldiv_negate, a conditional two's-complement of a parametrised width.
  - Instantiated for operand magnitudes and for the FIX sign correction.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFF9 (−7) → result=0xFFFFFFCF, done exactly at cycle 34, busy=1 in cycles 1..33.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
- DIVU a=5, b=0 → 0xFFFFFFFF, done at cycle 2; REM a=5, b=0 → 5; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Control:
  - start pulsed at cycle 10 while busy → ignored; the original result is unchanged.
  - rst_n low at cycle 15 → busy/done/result=0 immediately; no stray done afterwards.
- MULDIV_FUSE_EN: MULH a=3, b=−1, then MUL with the same operands → second result=0xFFFFFFFD with done at cycle 2; changing b afterwards → full 34-cycle latency.
